// File: rtl/pair_reduce.sv
// Pair reducer: reads an int_2 pair, emits its saturated signed sum plus a sequence number.
// Optional saturation counter enabled by defining PAIR_REDUCE_SATCNT_EN.
module pair_reduce #(
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0][DATA_W-1:0]   a_in,
  input  logic                     a_in_sync,
  output logic                     a_in_notify,
  output logic signed [DATA_W-1:0] s_out,
  input  logic                     s_out_sync,
  output logic                     s_out_notify,
`ifdef PAIR_REDUCE_SATCNT_EN
  output logic [SEQ_W-1:0]         sat_cnt,
`endif
  output logic [SEQ_W-1:0]         seq_out
);

  typedef enum logic [1:0] {
    READ    = 2'd0,
    COMPUTE = 2'd1,
    WRITE   = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state_q;
  logic [DATA_W-1:0]   elem0_q;
  logic [DATA_W-1:0]   elem1_q;
  logic [SEQ_W-1:0]    seqCnt_q;
  logic [SEQ_W-1:0]    seqOut_q;
  logic [DATA_W-1:0]   sum_q;
  logic                aNotify_q;
  logic                sNotify_q;
`ifdef PAIR_REDUCE_SATCNT_EN
  logic [SEQ_W-1:0]    satCnt_q;
`endif

  logic [DATA_W:0]     sumWide;
  logic                clamp;
  logic [DATA_W-1:0]   sum_d;

  // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
  always_comb begin
    sumWide = {elem0_q[DATA_W-1], elem0_q} + {elem1_q[DATA_W-1], elem1_q};
    clamp   = sumWide[DATA_W] ^ sumWide[DATA_W-1];
    sum_d   = sumWide[DATA_W-1:0];
    if (clamp) begin
      sum_d = sumWide[DATA_W] ? MIN_NEG : MAX_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= READ;
      elem0_q   <= '0;
      elem1_q   <= '0;
      seqCnt_q  <= '0;
      seqOut_q  <= '0;
      sum_q     <= '0;
      aNotify_q <= 1'b1;
      sNotify_q <= 1'b0;
`ifdef PAIR_REDUCE_SATCNT_EN
      satCnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        READ: begin
          if (a_in_sync) begin
            elem0_q   <= a_in[0];
            elem1_q   <= a_in[1];
            aNotify_q <= 1'b0;
            state_q   <= COMPUTE;
          end
        end
        COMPUTE: begin
          sum_q     <= sum_d;
          seqOut_q  <= seqCnt_q;
          seqCnt_q  <= seqCnt_q + SEQ_W'(1);
          sNotify_q <= 1'b1;
          state_q   <= WRITE;
`ifdef PAIR_REDUCE_SATCNT_EN
          if (clamp && (satCnt_q != {SEQ_W{1'b1}})) begin
            satCnt_q <= satCnt_q + SEQ_W'(1);
          end
`endif
        end
        WRITE: begin
          // Producer-side sync is ignored here; the pair is only read back in READ.
          if (s_out_sync) begin
            sNotify_q <= 1'b0;
            aNotify_q <= 1'b1;
            state_q   <= READ;
          end
        end
        default: begin
          aNotify_q <= 1'b1;
          sNotify_q <= 1'b0;
          state_q   <= READ;
        end
      endcase
    end
  end

  assign a_in_notify  = aNotify_q;
  assign s_out_notify = sNotify_q;
  assign s_out        = sum_q;
  assign seq_out      = seqOut_q;
`ifdef PAIR_REDUCE_SATCNT_EN
  assign sat_cnt      = satCnt_q;
`endif

endmodule

// File: tb/tb_pair_reduce.sv
// Self-checking bench for pair_reduce: directed and random pairs against an arithmetic reference model.
// Also covers the PAIR_REDUCE_SATCNT_EN build when that macro is defined.
module tb_pair_reduce;

  logic              clk;
  logic              rst;
  logic [1:0][31:0]  a_in;
  logic              a_in_sync;
  logic              a_in_notify;
  logic [31:0]       s_out;
  logic              s_out_sync;
  logic              s_out_notify;
  logic [7:0]        seq_out;
`ifdef PAIR_REDUCE_SATCNT_EN
  logic [7:0]        sat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: sequence number of the next result and clamp count.
  int modelSeq = 0;
  int modelSat = 0;

  pair_reduce #(.DATA_W(32), .SEQ_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_in         (a_in),
    .a_in_sync    (a_in_sync),
    .a_in_notify  (a_in_notify),
    .s_out        (s_out),
    .s_out_sync   (s_out_sync),
    .s_out_notify (s_out_notify),
`ifdef PAIR_REDUCE_SATCNT_EN
    .sat_cnt      (sat_cnt),
`endif
    .seq_out      (seq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint exactSum(input logic [31:0] x, input logic [31:0] y);
    return longint'($signed(x)) + longint'($signed(y));
  endfunction

  function automatic logic [31:0] refSum(input logic [31:0] x, input logic [31:0] y);
    longint s;
    logic [63:0] bits;
    s = exactSum(x, y);
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
    bits = 64'(s);
    return bits[31:0];
  endfunction

  function automatic bit refClamp(input logic [31:0] x, input logic [31:0] y);
    longint s;
    s = exactSum(x, y);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    modelSeq = 0;
    modelSat = 0;
  endtask

  // One full transaction; holdCycles is how long the consumer stalls after s_out_notify rises.
  task automatic applyStimulus(input logic [31:0] a0, input logic [31:0] a1, input int holdCycles);
    int waitCnt;
    logic [31:0] expSum;
    logic [7:0]  expSeq;
    waitCnt = 0;
    while (a_in_notify !== 1'b1 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("aNotifyReady", 64'(a_in_notify), 64'd1);
    expSum = refSum(a0, a1);
    expSeq = 8'(modelSeq);
    a_in[0]   = a0;
    a_in[1]   = a1;
    a_in_sync = 1'b1;
    tick();
    a_in_sync = 1'b0;
    checkOutput("aNotifyDrop", 64'(a_in_notify), 64'd0);
    checkOutput("sNotifyCompute", 64'(s_out_notify), 64'd0);
    tick();
    checkOutput("sNotifyRise", 64'(s_out_notify), 64'd1);
    checkOutput("sumValue", 64'(s_out), 64'(expSum));
    checkOutput("seqValue", 64'(seq_out), 64'(expSeq));
    modelSeq = (modelSeq + 1) % 256;
    if (refClamp(a0, a1) && modelSat < 255) modelSat++;
    for (int i = 0; i < holdCycles; i++) begin
      a_in[0]   = $urandom;
      a_in[1]   = $urandom;
      a_in_sync = 1'b1;
      tick();
      checkOutput("holdSum", 64'(s_out), 64'(expSum));
      checkOutput("holdSeq", 64'(seq_out), 64'(expSeq));
      checkOutput("holdANotify", 64'(a_in_notify), 64'd0);
      checkOutput("holdSNotify", 64'(s_out_notify), 64'd1);
    end
    a_in_sync  = 1'b0;
    s_out_sync = 1'b1;
    tick();
    s_out_sync = 1'b0;
    checkOutput("backToRead", 64'(a_in_notify), 64'd1);
    checkOutput("sNotifyFall", 64'(s_out_notify), 64'd0);
    checkOutput("sumHeld", 64'(s_out), 64'(expSum));
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 3))
      0: return 32'h7FFFFFFF - 32'($urandom_range(0, 3));
      1: return 32'h80000000 + 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst        = 1'b0;
    a_in       = '0;
    a_in_sync  = 1'b0;
    s_out_sync = 1'b0;
    @(negedge clk);

    $display("[TB] reset");
    doReset(2);
    checkOutput("rstANotify", 64'(a_in_notify), 64'd1);
    checkOutput("rstSNotify", 64'(s_out_notify), 64'd0);
    checkOutput("rstSum", 64'(s_out), 64'd0);
    checkOutput("rstSeq", 64'(seq_out), 64'd0);

    $display("[TB] basic pair");
    applyStimulus(32'd5, -32'sd3, 0);
    checkOutput("basicSum", 64'(s_out), 64'd2);

    $display("[TB] saturation");
    applyStimulus(32'h7FFFFFFF, 32'd1, 0);
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 0);
`ifdef PAIR_REDUCE_SATCNT_EN
    checkOutput("satCnt", 64'(sat_cnt), 64'(modelSat));
    checkOutput("satCntTwo", 64'(sat_cnt), 64'd2);
`endif

    $display("[TB] backpressure");
    applyStimulus(32'd1000, 32'd234, 10);
    applyStimulus(32'd7, 32'd8, 0);

    $display("[TB] random pairs");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(randOperand(), randOperand(), int'($urandom_range(0, 2)));
    end
`ifdef PAIR_REDUCE_SATCNT_EN
    checkOutput("satCntRandom", 64'(sat_cnt), 64'(modelSat));
`endif

    $display("[TB] sequence wrap");
    doReset(2);
    for (int i = 0; i < 257; i++) begin
      applyStimulus($urandom, $urandom, 0);
    end
    checkOutput("wrapSeq257", 64'(seq_out), 64'd0);

    $display("[TB] reset during write");
    applyStimulus(32'd11, 32'd22, 0);
    a_in[0]   = 32'd3;
    a_in[1]   = 32'd4;
    a_in_sync = 1'b1;
    tick();
    a_in_sync = 1'b0;
    tick();
    checkOutput("preRstSNotify", 64'(s_out_notify), 64'd1);
    checkOutput("preRstSeq", 64'(seq_out), 64'd2);
    doReset(1);
    checkOutput("midRstSNotify", 64'(s_out_notify), 64'd0);
    checkOutput("midRstANotify", 64'(a_in_notify), 64'd1);
    checkOutput("midRstSeq", 64'(seq_out), 64'd0);
    checkOutput("midRstSum", 64'(s_out), 64'd0);
    applyStimulus(-32'sd40, 32'd2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
